// File: rtl/common.sv
// Shared ISA definitions: ALU operation enum plus opcode and funct encodings.
package common;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_SLT = 3'd5,
    ALU_LUI = 3'd6
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/pipes.sv
// Pipeline register bundles between fetch, decode and execute.
package pipes;
  import common::*;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } f_d_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        use_rs;
    logic        use_rt;
    alu_op_t     alu_op;
  } d_e_reg_t;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, 2 read / 1 write, $0 hardwired to zero.
// DECODE_WB_BYPASS_EN: same-cycle write data is forwarded to matching reads.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, register read, load-use stall and flush.
// Register-file write bypass is selected by DECODE_WB_BYPASS_EN (see regfile).
module decode_stage
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  f_d_reg_t    f_d_reg,
  input  logic        f_valid,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        e_mem_read,
  input  logic [4:0]  e_dst,
  output d_e_reg_t    d_e_reg,
  output logic        d_e_valid,
  output logic        stall,
  output logic        illegal
);

  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] sext;
  logic        ill;
  logic        rtype_ok;
  d_e_reg_t    dec;

  assign instr = f_d_reg.instruction;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (f_d_reg.rs),
    .ra2   (f_d_reg.rt),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  always_comb begin
    dec               = '0;
    ill               = 1'b0;
    rtype_ok          = 1'b0;
    sext              = {{16{instr[15]}}, instr[15:0]};
    dec.pc            = f_d_reg.pc;
    dec.pc_plus_4     = f_d_reg.pc_plus_4;
    dec.rs_data       = rs_data;
    dec.rt_data       = rt_data;
    dec.rs            = f_d_reg.rs;
    dec.rt            = f_d_reg.rt;
    dec.branch_target = f_d_reg.pc_plus_4 + (sext << 2);
    dec.jump_target   = {f_d_reg.pc_plus_4[31:28], instr[25:0], 2'b00};
    case (instr[31:26])
      OP_RTYPE: begin
        rtype_ok = 1'b1;
        case (instr[5:0])
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: rtype_ok = 1'b0;
        endcase
        if (rtype_ok) begin
          dec.reg_write = 1'b1;
          dec.dst       = instr[15:11];
          dec.use_rs    = 1'b1;
          dec.use_rt    = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OP_ADDIU: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.dst       = instr[20:16];
        dec.use_rs    = 1'b1;
        dec.imm       = sext;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_LUI;
        dec.dst       = instr[20:16];
        dec.imm       = {instr[15:0], 16'd0};
      end
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.dst       = instr[20:16];
        dec.use_rs    = 1'b1;
        dec.imm       = sext;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.use_rs    = 1'b1;
        dec.use_rt    = 1'b1;
        dec.imm       = sext;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
        dec.imm    = sext;
      end
      OP_J:    dec.jump = 1'b1;
      default: ill = 1'b1;
    endcase
    // An empty slot carries nothing downstream and can never hazard.
    if (!f_valid) begin
      dec = '0;
      ill = 1'b0;
    end
  end

  assign stall = !flush && e_mem_read && (e_dst != 5'd0) &&
                 ((dec.use_rs && f_d_reg.rs == e_dst) ||
                  (dec.use_rt && f_d_reg.rt == e_dst));

  d_e_reg_t de_d, de_q;
  logic     valid_d, valid_q;
  logic     illegal_d, illegal_q;

  always_comb begin
    de_d      = dec;
    valid_d   = f_valid;
    illegal_d = ill;
    if (flush || stall) begin
      de_d      = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      de_q      <= de_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign d_e_reg   = de_q;
  assign d_e_valid = valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hand sequences,
// expected records queued at drive time and popped when the stage register updates.
module tb_decode_stage;
  import common::*;
  import pipes::*;

  logic        clk;
  logic        reset;
  f_d_reg_t    f_d_reg;
  logic        f_valid;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        e_mem_read;
  logic [4:0]  e_dst;
  d_e_reg_t    d_e_reg;
  logic        d_e_valid;
  logic        stall;
  logic        illegal;

  decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .f_d_reg    (f_d_reg),
    .f_valid    (f_valid),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .e_mem_read (e_mem_read),
    .e_dst      (e_dst),
    .d_e_reg    (d_e_reg),
    .d_e_valid  (d_e_valid),
    .stall      (stall),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] instr;
    logic        fv, fl, emr;
    logic [4:0]  edst;
    logic        x_stall, x_valid, x_rw, x_mr, x_mw;
    alu_op_t     x_alu;
    logic [4:0]  x_dst;
    logic [31:0] x_imm, x_rsd, x_rtd;
    logic        x_ill;
  } vec_t;

  int   n_total = 0;
  int   n_pass  = 0;
  vec_t sb[$];
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input vec_t e, input string tag);
    chk({tag, ".valid"},   32'(d_e_valid),         32'(e.x_valid));
    chk({tag, ".rw"},      32'(d_e_reg.reg_write), 32'(e.x_rw));
    chk({tag, ".mr"},      32'(d_e_reg.mem_read),  32'(e.x_mr));
    chk({tag, ".mw"},      32'(d_e_reg.mem_write), 32'(e.x_mw));
    chk({tag, ".alu"},     32'(d_e_reg.alu_op),    32'(e.x_alu));
    chk({tag, ".dst"},     32'(d_e_reg.dst),       32'(e.x_dst));
    chk({tag, ".imm"},     d_e_reg.imm,            e.x_imm);
    chk({tag, ".rs_data"}, d_e_reg.rs_data,        e.x_rsd);
    chk({tag, ".rt_data"}, d_e_reg.rt_data,        e.x_rtd);
    chk({tag, ".illegal"}, 32'(illegal),           32'(e.x_ill));
  endtask

  task automatic apply(input vec_t v, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input string tag);
    vec_t e;
    @(negedge clk);
    f_d_reg.instruction = v.instr;
    f_d_reg.rs          = v.instr[25:21];
    f_d_reg.rt          = v.instr[20:16];
    f_d_reg.pc          = 32'hA000_1000;
    f_d_reg.pc_plus_4   = 32'hA000_1004;
    f_valid             = v.fv;
    flush               = v.fl;
    e_mem_read          = v.emr;
    e_dst               = v.edst;
    wb_en               = we;
    wb_addr             = wa;
    wb_data             = wd;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(v.x_stall));
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e, tag);
  endtask

  vec_t vidle, vb, vr;

  initial begin
    vecs[0]  = '{32'h2405FFFD,1,0,0,5'd0,  0,1,1,0,0, ALU_ADD,5'd5,32'hFFFFFFFD,32'h0, 32'h0, 0};
    vecs[1]  = '{32'h010A4821,1,0,0,5'd0,  0,1,1,0,0, ALU_ADD,5'd9,32'h0,       32'h88,32'hAA,0};
    vecs[2]  = '{32'h010A1823,1,0,0,5'd0,  0,1,1,0,0, ALU_SUB,5'd3,32'h0,       32'h88,32'hAA,0};
    vecs[3]  = '{32'h010A1824,1,0,0,5'd0,  0,1,1,0,0, ALU_AND,5'd3,32'h0,       32'h88,32'hAA,0};
    vecs[4]  = '{32'h010A1825,1,0,0,5'd0,  0,1,1,0,0, ALU_OR, 5'd3,32'h0,       32'h88,32'hAA,0};
    vecs[5]  = '{32'h010A182A,1,0,0,5'd0,  0,1,1,0,0, ALU_SLT,5'd3,32'h0,       32'h88,32'hAA,0};
    vecs[6]  = '{32'h3C071234,1,0,0,5'd0,  0,1,1,0,0, ALU_LUI,5'd7,32'h12340000,32'h0, 32'h0, 0};
    vecs[7]  = '{32'h8D060008,1,0,0,5'd0,  0,1,1,1,0, ALU_ADD,5'd6,32'h8,       32'h88,32'h0, 0};
    vecs[8]  = '{32'hAD0AFFFC,1,0,0,5'd0,  0,1,0,0,1, ALU_ADD,5'd0,32'hFFFFFFFC,32'h88,32'hAA,0};
    vecs[9]  = '{32'h110AFFFE,1,0,0,5'd0,  0,1,0,0,0, ALU_SUB,5'd0,32'hFFFFFFFE,32'h88,32'hAA,0};
    vecs[10] = '{32'h08000040,1,0,0,5'd0,  0,1,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};
    vecs[11] = '{32'hFC000000,1,0,0,5'd0,  0,1,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 1};
    vecs[12] = '{32'h010A4821,0,0,1,5'd8,  0,0,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};
    vecs[13] = '{32'h010A4821,1,1,1,5'd8,  0,0,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};
    vecs[14] = '{32'h010A4821,1,0,1,5'd8,  1,0,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};
    vecs[15] = '{32'h010A4821,1,0,1,5'd10, 1,0,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};
    vecs[16] = '{32'h010A4821,1,0,0,5'd8,  0,1,1,0,0, ALU_ADD,5'd9,32'h0,       32'h88,32'hAA,0};
    vecs[17] = '{32'h2405FFFD,1,0,1,5'd0,  0,1,1,0,0, ALU_ADD,5'd5,32'hFFFFFFFD,32'h0, 32'h0, 0};
    vecs[18] = '{32'h8D060008,1,0,1,5'd6,  0,1,1,1,0, ALU_ADD,5'd6,32'h8,       32'h88,32'h0, 0};
    vecs[19] = '{32'h010A4821,1,0,1,5'd9,  0,1,1,0,0, ALU_ADD,5'd9,32'h0,       32'h88,32'hAA,0};
    vidle    = '{32'h0,       0,0,0,5'd0,  0,0,0,0,0, ALU_NOP,5'd0,32'h0,       32'h0, 32'h0, 0};

    reset = 1'b1;
    f_d_reg = '0;
    f_valid = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    e_mem_read = 1'b0;
    e_dst = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid",   32'(d_e_valid),       32'd0);
    chk("reset.illegal", 32'(illegal),         32'd0);
    chk("reset.bundle",  32'(d_e_reg != '0),   32'd0);
    chk("reset.stall",   32'(stall),           32'd0);
    @(negedge clk);
    reset = 1'b0;

    apply(vidle, 1'b1, 5'd8,  32'h88,   "wr8");
    apply(vidle, 1'b1, 5'd10, 32'hAA,   "wr10");
    apply(vidle, 1'b1, 5'd0,  32'hFFFF, "wr0");

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], 1'b0, 5'd0, 32'd0, $sformatf("row%0d", i));
      if (i == 1) chk("row1.pc", d_e_reg.pc, 32'hA000_1000);
      if (i == 9) begin
        chk("beq.branch", 32'(d_e_reg.branch), 32'd1);
        chk("beq.target", d_e_reg.branch_target, 32'hA000_0FFC);
      end
      if (i == 10) begin
        chk("j.jump",   32'(d_e_reg.jump), 32'd1);
        chk("j.target", d_e_reg.jump_target, 32'hA000_0100);
      end
    end

    // Same-cycle write and read of $4, then the following read.
    vb = '{32'h00804821,1,0,0,5'd0, 0,1,1,0,0, ALU_ADD,5'd9,32'h0,32'h0,32'h0,0};
`ifdef DECODE_WB_BYPASS_EN
    vb.x_rsd = 32'h1234;
`endif
    apply(vb, 1'b1, 5'd4, 32'h1234, "byp_same");
    vb.x_rsd = 32'h1234;
    apply(vb, 1'b0, 5'd0, 32'd0, "byp_next");

    // Illegal pulse, then reset asserted while a stall condition is pending.
    apply(vecs[11], 1'b0, 5'd0, 32'd0, "ill");
    apply(vecs[14], 1'b0, 5'd0, 32'd0, "pre_rst_stall");
    @(negedge clk);
    reset = 1'b1;
    f_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2.valid",   32'(d_e_valid),     32'd0);
    chk("rst2.illegal", 32'(illegal),       32'd0);
    chk("rst2.bundle",  32'(d_e_reg != '0), 32'd0);
    chk("rst2.stall",   32'(stall),         32'd0);
    @(negedge clk);
    reset = 1'b0;
    vr = vecs[16];
    vr.x_rsd = 32'h0;
    vr.x_rtd = 32'h0;
    apply(vr, 1'b0, 5'd0, 32'd0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port f_d_reg, input, f_d_reg_t, fetch bundle with fields instruction, pc, pc_plus_4, rs and rt.
REQ-004 SHALL have port f_valid, input, 1, meaning f_d_reg holds a real instruction this cycle.
REQ-005 SHALL have port flush, input, 1, meaning a taken branch or jump kills the instruction being decoded.
REQ-006 SHALL have ports wb_en (input, 1), wb_addr (input, 5) and wb_data (input, 32), the register-file write port.
REQ-007 SHALL have ports e_mem_read (input, 1) and e_dst (input, 5), describing the load currently in execute.
REQ-008 SHALL have port d_e_reg, output, d_e_reg_t, the registered decode bundle.
REQ-009 SHALL have port d_e_valid, output, 1, registered.
REQ-010 SHALL have port stall, output, 1, combinational; fetch holds its PC and instruction while it is 1.
REQ-011 SHALL have port illegal, output, 1, registered; it is 1 for one cycle after an unsupported opcode is decoded.

Function
REQ-012 SHALL decode opcode/funct into these control fields:
- reg_write, mem_read, mem_write, alu_op (package enum), dst (rd for R-type, rt for I-type), use_rs, use_rt.
REQ-013 SHALL support addu, subu, and, or, slt, addiu, lui, lw, sw, beq and j; any other encoding decodes as a NOP with illegal=1.
REQ-014 SHALL sign-extend the 16-bit immediate for addiu/lw/sw/beq and shift it left 16 bits for lui.
REQ-015 SHALL compute the branch target as pc_plus_4 + (sext(imm) << 2), and the jump target as {pc_plus_4[31:28], instr[25:0], 2'b00}.
REQ-016 SHALL read rs and rt from a 32x32 register file; register 0 always reads 0 and writes to it are ignored.
REQ-017 SHALL raise stall (load-use hazard) when e_mem_read=1, e_dst!=0, f_valid=1 and e_dst matches rs (with use_rs) or rt (with use_rt).
REQ-018 During a stall, SHALL load a bubble (d_e_valid<=0, all control fields 0) and leave fetch's instruction to be re-decoded next cycle.
REQ-019 flush SHALL have priority over stall: d_e_valid<=0, illegal<=0, and stall forced to 0 in that cycle.
REQ-020 Otherwise, d_e_reg<=decoded bundle and d_e_valid<=f_valid, with a latency of exactly 1 cycle.
REQ-021 When f_valid=0, control fields SHALL be zero and no stall SHALL be raised.
REQ-022 A register-file write SHALL commit on the clock edge regardless of stall or flush.

Reset
REQ-023 On reset: d_e_reg all zero, d_e_valid=0, illegal=0, and all 32 registers cleared to 0.
REQ-024 A reset asserted mid-stall SHALL override it; stall=0 in the cycle after reset because f_valid is expected low during reset.

Configuration
REQ-025 Macro DECODE_WB_BYPASS_EN, when defined: a read of wb_addr (nonzero) while wb_en=1 in the same cycle returns wb_data.
REQ-026 Without DECODE_WB_BYPASS_EN: the same-cycle read returns the old register value, and the write becomes visible the next cycle.

Structure
REQ-027 d_e_reg_t SHALL live in package pipes; the alu_op enum and opcode/funct constants SHALL live in package common.
REQ-028 The register file SHALL be a sub-module regfile (2 read ports, 1 write port, bypass controlled by the macro).

Verification
REQ-029 Decode test: addiu $5,$0,-3 (0x2405FFFD), f_valid=1 -> next cycle d_e_valid=1, imm=0xFFFFFFFD, dst=5, reg_write=1, alu_op=ADD.
REQ-030 Load-use test: e_mem_read=1, e_dst=8, instruction addu $9,$8,$10 -> stall=1 and d_e_valid=0 next cycle; when e_mem_read drops, the instruction issues one cycle later.
REQ-031 Flush test: flush=1 together with the stall condition -> stall=0, d_e_valid=0 next cycle.
REQ-032 Bypass test: wb_en=1, wb_addr=4, wb_data=0x1234 while decoding a reader of $4 -> value 0x1234 with the macro, 0 without.
REQ-033 Zero-register test: write wb_addr=0 with 0xFFFF -> a later read of $0 returns 0.
REQ-034 Illegal test: opcode 0x3F -> illegal=1 for one cycle, all control fields 0; reset then gives all outputs 0.
